instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Fetch controller between the PC register and instruction memory. Latches the
//  current PC, issues a req/ready read to imem, holds the returned word for decode,
//  and pulses instr_read to advance the PC (PC updates on negedge clk) once decode
//  accepts the instruction. Flags misaligned PCs and memory timeouts.
// PARAMETERS
//  ADDR_W         32   PC / imem address width
//  DATA_W         32   instruction width
//  TIMEOUT_CYCLES 16   max REQ cycles without imem_ready before error (>=1)
// PORTS
//  clk          in   1       system clock, all state on posedge
//  rst_n        in   1       asynchronous, active-low reset
//  pc_addr      in   ADDR_W  current PC from PC register
//  stall        in   1       decode/execute not ready to consume instr
//  imem_req     out  1       read request to instruction memory
//  imem_addr    out  ADDR_W  word address of request (PC latched in addr_q)
//  imem_ready   in   1       imem_rdata valid this cycle
//  imem_rdata   in   DATA_W  instruction word from memory
//  instr        out  DATA_W  held instruction to decode
//  instr_pc     out  ADDR_W  PC of held instruction
//  instr_valid  out  1       instr/instr_pc valid
//  instr_read   out  1       1-cycle pulse: PC may load next address
//  fetch_err    out  1       sticky error flag
//  err_code     out  2       00 none, 01 misaligned PC, 10 imem timeout
// BEHAVIOUR
//  Reset (rst_n=0, any time, async): state=IDLE; imem_req, instr_valid, instr_read,
//   fetch_err=0; instr, instr_pc, imem_addr, err_code, timeout cnt=0. Outstanding
//   request abandoned; a late imem_ready after reset is ignored.
//  States: IDLE, REQ, VALID, ERR.
//  IDLE: addr_q<=pc_addr. If pc_addr[1:0]!=0 -> ERR, err_code=01; else -> REQ, cnt=0.
//  REQ: imem_req=1, imem_addr=addr_q (stable while in REQ). cnt++ each cycle.
//   imem_ready=1 -> instr<=imem_rdata, instr_pc<=addr_q, -> VALID (ready checked
//   before timeout when both occur same cycle). Min latency REQ->VALID = 1 cycle.
//   cnt==TIMEOUT_CYCLES-1 and !imem_ready -> ERR, err_code=10, imem_req drops.
//  VALID: instr_valid=1, instr held constant. stall=1 -> stay, instr_read=0.
//   stall=0 -> instr_read=1 this cycle (combinational from state & !stall),
//   -> IDLE. PC loads next address on following negedge; IDLE samples it on
//   next posedge. Thus one instruction per 3 cycles min (IDLE,REQ,VALID).
//  ERR: fetch_err=1, imem_req=0, instr_valid=0, instr_read=0; held until rst_n.
//  imem_ready outside REQ is ignored. instr_read never asserted outside VALID.
//  No wrap-around handling needed: PC arithmetic is modulo 2^ADDR_W upstream;
//   addr 0xFFFF_FFFC is fetched normally.
// TESTING
//  1. Reset, pc_addr=0x0, imem_ready same cycle as req, rdata=0x00500093, stall=0
//     -> instr=0x00500093, instr_pc=0, instr_valid 1 cycle, single instr_read pulse.
//  2. imem_ready delayed 5 cycles, TIMEOUT=16 -> imem_req high 6 cycles, addr
//     stable, no error, correct instr latched.
//  3. VALID with stall=1 for 4 cycles -> instr/instr_valid held, instr_read=0;
//     stall drops -> exactly one instr_read pulse, next fetch at new PC (0x4).
//  4. imem_ready never asserted -> after 16 REQ cycles fetch_err=1, err_code=10,
//     imem_req=0, sticky until rst_n.
//  5. pc_addr=0x0000_0006 -> no imem_req, fetch_err=1, err_code=01.
//  6. rst_n pulled low mid-REQ and mid-VALID -> all outputs zero immediately
//     (async), late imem_ready ignored, clean fetch from IDLE after release.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch controller between PC register and imem
//
// Purpose:
//   Latches the current PC, issues a req/ready read to instruction memory, holds
//   the returned word for decode and pulses instr_read_o so the PC register can
//   advance (it loads on the following negedge). Misaligned PCs and memory
//   timeouts park the unit in a sticky error state until reset.
//
// Ports:
//   clk           system clock, all state on posedge
//   rst_n         asynchronous active-low reset
//   pc_addr_i     current PC from the PC register
//   stall_i       decode/execute not ready to consume the held instruction
//   imem_req_o    read request to instruction memory
//   imem_addr_o   address of the request (PC latched in IDLE)
//   imem_ready_i  imem_rdata_i valid this cycle
//   imem_rdata_i  instruction word from memory
//   instr_o       held instruction to decode
//   instr_pc_o    PC of the held instruction
//   instr_valid_o instr_o / instr_pc_o valid
//   instr_read_o  one-cycle pulse: PC may load the next address
//   fetch_err_o   sticky error flag
//   err_code_o    00 none, 01 misaligned PC, 10 imem timeout

module instr_fetch_unit #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc_addr_i,
  input  logic              stall_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_ready_i,
  input  logic [DATA_W-1:0] imem_rdata_i,
  output logic [DATA_W-1:0] instr_o,
  output logic [ADDR_W-1:0] instr_pc_o,
  output logic              instr_valid_o,
  output logic              instr_read_o,
  output logic              fetch_err_o,
  output logic [1:0]        err_code_o
);

  // Counter only has to reach TIMEOUT_CYCLES-1.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ERR_NONE      = 2'b00;
  localparam logic [1:0] ERR_MISALIGN  = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT   = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_VALID = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] instr_q;
  logic [ADDR_W-1:0] instr_pc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [1:0]        err_code_q;
  logic              imem_req_q;
  logic              instr_valid_q;
  logic              fetch_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      cnt_q         <= '0;
      err_code_q    <= ERR_NONE;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          addr_q <= pc_addr_i;
          cnt_q  <= '0;
          if (pc_addr_i[1:0] != 2'b00) begin
            state_q     <= S_ERR;
            err_code_q  <= ERR_MISALIGN;
            fetch_err_q <= 1'b1;
          end else begin
            state_q    <= S_REQ;
            imem_req_q <= 1'b1;
          end
        end

        S_REQ: begin
          // Data arriving on the last allowed cycle still wins over the timeout.
          if (imem_ready_i) begin
            instr_q       <= imem_rdata_i;
            instr_pc_q    <= addr_q;
            state_q       <= S_VALID;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b1;
          end else if (cnt_q == CNT_MAX) begin
            state_q     <= S_ERR;
            err_code_q  <= ERR_TIMEOUT;
            imem_req_q  <= 1'b0;
            fetch_err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        S_VALID: begin
          if (!stall_i) begin
            state_q       <= S_IDLE;
            instr_valid_q <= 1'b0;
          end
        end

        S_ERR: begin
          // Sticky until reset.
          state_q <= S_ERR;
        end

        default: begin
          state_q       <= S_IDLE;
          imem_req_q    <= 1'b0;
          instr_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req_o    = imem_req_q;
  assign imem_addr_o   = addr_q;
  assign instr_o       = instr_q;
  assign instr_pc_o    = instr_pc_q;
  assign instr_valid_o = instr_valid_q;
  assign fetch_err_o   = fetch_err_q;
  assign err_code_o    = err_code_q;

  // Combinational so the PC register can load on the negedge of the accept cycle.
  assign instr_read_o  = (state_q == S_VALID) && !stall_i;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard bench for instr_fetch_unit

module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc_addr = 32'h0;
  logic        stall = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_read;
  logic        fetch_err;
  logic [1:0]  err_code;

  instr_fetch_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pc_addr_i    (pc_addr),
    .stall_i      (stall),
    .imem_req_o   (imem_req),
    .imem_addr_o  (imem_addr),
    .imem_ready_i (imem_ready),
    .imem_rdata_i (imem_rdata),
    .instr_o      (instr),
    .instr_pc_o   (instr_pc),
    .instr_valid_o(instr_valid),
    .instr_read_o (instr_read),
    .fetch_err_o  (fetch_err),
    .err_code_o   (err_code)
  );

  always #10 clk = ~clk;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   delay_q[$];
  int   stall_q[$];
  int   req_runs[$];
  int   accepted = 0;
  logic late_ready = 1'b0;
  logic saw_req = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0050_0093;
      32'h0000_0004: return 32'h0010_0113;
      32'h0000_0008: return 32'h0020_81b3;
      32'h0000_000C: return 32'h4020_8233;
      32'h0000_0020: return 32'h00c0_006f;
      32'h0000_0024: return 32'hfe01_0113;
      32'h0000_0030: return 32'h0000_8067;
      default:       return 32'hdead_beef;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check_b({tag, "_req"}, imem_req, 1'b0);
    check_b({tag, "_valid"}, instr_valid, 1'b0);
    check_b({tag, "_read"}, instr_read, 1'b0);
    check_b({tag, "_err"}, fetch_err, 1'b0);
    check({tag, "_code"}, {30'h0, err_code}, 32'h0);
    check({tag, "_instr"}, instr, 32'h0);
    check({tag, "_ipc"}, instr_pc, 32'h0);
    check({tag, "_addr"}, imem_addr, 32'h0);
  endtask

  // which: 0 accepted>=arg, 1 instr_valid, 2 fetch_err, 3 imem_req
  task automatic wait_for(input int which, input int arg, input int budget, input string name);
    int n = 0;
    bit hit = 1'b0;
    while (!hit && n < budget) begin
      @(posedge clk);
      #3;
      case (which)
        0:       hit = (accepted >= arg);
        1:       hit = instr_valid;
        2:       hit = fetch_err;
        default: hit = imem_req;
      endcase
      n++;
    end
    if (!hit) begin
      total++;
      bad++;
      $display("FAIL %s: timeout after %0d cycles", name, budget);
    end
  endtask

  // Memory model: answers after a per-fetch number of extra REQ cycles (-1 = never).
  int rcnt = 0;
  int rdelay = 0;
  always @(negedge clk) begin
    if (imem_req) begin
      saw_req = 1'b1;
      if (rcnt == 0) rdelay = (delay_q.size() > 0) ? delay_q.pop_front() : 0;
      check("imem_addr_vs_pc", imem_addr, pc_addr);
      if (rdelay >= 0 && rcnt == rdelay) begin
        imem_ready = 1'b1;
        imem_rdata = mem_word(imem_addr);
      end else begin
        imem_ready = late_ready;
        imem_rdata = 32'h0bad_0bad;
      end
      rcnt++;
    end else begin
      if (rcnt > 0) req_runs.push_back(rcnt);
      rcnt = 0;
      imem_ready = late_ready;
      imem_rdata = late_ready ? 32'hbadb_ad00 : 32'h0;
    end
  end

  // PC register: advances on the negedge of an accept cycle.
  always @(negedge clk) begin
    if (instr_read) pc_addr = pc_addr + 32'd4;
  end

  // Decode model: stalls each held instruction for a per-fetch number of cycles.
  int vcnt = 0;
  int need = 0;
  always @(posedge clk) begin
    #1;
    if (instr_valid) begin
      if (vcnt == 0) need = (stall_q.size() > 0) ? stall_q.pop_front() : 1000000;
      stall = (vcnt < need);
      vcnt++;
    end else begin
      vcnt  = 0;
      stall = 1'b1;
    end
  end

  // Scoreboard monitor.
  logic        prev_read = 1'b0;
  logic        prev_valid = 1'b0;
  logic [31:0] prev_instr = 32'h0;
  always @(negedge clk) begin
    exp_t e;
    if (instr_valid) check_b("read_vs_stall", instr_read, !stall);
    if (instr_read) begin
      check_b("read_only_in_valid", instr_valid, 1'b1);
      check_b("read_single_pulse", prev_read, 1'b0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got instr %h pc %h expected none", instr, instr_pc);
      end else begin
        e = exp_q.pop_front();
        check("sb_instr", instr, e.instr);
        check("sb_pc", instr_pc, e.pc);
      end
      accepted++;
    end
    if (instr_valid && prev_valid && !prev_read) check("hold_instr", instr, prev_instr);
    prev_read  = instr_read;
    prev_valid = instr_valid;
    prev_instr = instr;
  end

  initial begin
    // Reset state, back-to-back fetch, delayed ready, stalled decode.
    delay_q = '{0, 5, 0};
    stall_q = '{0, 0, 4};
    exp_q.push_back('{32'h0050_0093, 32'h0000_0000});
    exp_q.push_back('{32'h0010_0113, 32'h0000_0004});
    exp_q.push_back('{32'h0020_81b3, 32'h0000_0008});
    repeat (2) @(posedge clk);
    #3;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    wait_for(0, 3, 200, "accept_3");
    wait_for(1, 0, 50, "valid_next");
    check("next_pc", instr_pc, 32'h0000_000C);
    check("next_instr", instr, 32'h4020_8233);
    check_b("no_err_a", fetch_err, 1'b0);
    check("req_runs_cnt", (req_runs.size() >= 3) ? 32'd1 : 32'd0, 32'd1);
    if (req_runs.size() >= 3) begin
      check("req_len_0", req_runs[0], 32'd1);
      check("req_len_1", req_runs[1], 32'd6);
      check("req_len_2", req_runs[2], 32'd1);
    end

    // Timeout: ready never comes.
    rst_n = 1'b0;
    delay_q = '{-1};
    stall_q.delete();
    pc_addr = 32'h0000_0010;
    repeat (2) @(posedge clk);
    #3;
    req_runs.delete();
    rst_n = 1'b1;
    wait_for(2, 0, 40, "timeout_err");
    check("timeout_code", {30'h0, err_code}, 32'h2);
    check_b("timeout_req", imem_req, 1'b0);
    check_b("timeout_valid", instr_valid, 1'b0);
    repeat (5) @(posedge clk);
    #3;
    check_b("timeout_sticky", fetch_err, 1'b1);
    check("timeout_sticky_code", {30'h0, err_code}, 32'h2);
    check("timeout_req_len", (req_runs.size() > 0) ? req_runs[0] : 0, 32'd16);

    // Misaligned PC.
    rst_n = 1'b0;
    delay_q.delete();
    pc_addr = 32'h0000_0006;
    repeat (2) @(posedge clk);
    #3;
    saw_req = 1'b0;
    rst_n = 1'b1;
    wait_for(2, 0, 10, "misalign_err");
    check("misalign_code", {30'h0, err_code}, 32'h1);
    check_b("misalign_no_req", saw_req, 1'b0);
    check_b("misalign_valid", instr_valid, 1'b0);

    // Async reset mid-REQ with a late ready, then a clean fetch.
    rst_n = 1'b0;
    pc_addr = 32'h0000_0020;
    delay_q = '{3, 0};
    stall_q = '{2};
    exp_q.push_back('{32'h00c0_006f, 32'h0000_0020});
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    wait_for(3, 0, 10, "req_start");
    @(posedge clk);
    #3;
    check_b("mid_req_req", imem_req, 1'b1);
    check("mid_req_addr", imem_addr, 32'h0000_0020);
    #2;
    rst_n = 1'b0;
    late_ready = 1'b1;
    #2;
    check_zero("rst_mid_req");
    repeat (2) @(posedge clk);
    #3;
    check("late_ready_instr", instr, 32'h0);
    check_b("late_ready_valid", instr_valid, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    late_ready = 1'b0;
    wait_for(0, 4, 50, "accept_after_reset");
    wait_for(1, 0, 50, "valid_0x24");
    check("valid_0x24_pc", instr_pc, 32'h0000_0024);
    check("valid_0x24_instr", instr, 32'hfe01_0113);

    // Async reset mid-VALID, then a clean fetch.
    #2;
    rst_n = 1'b0;
    #2;
    check_zero("rst_mid_valid");
    pc_addr = 32'h0000_0030;
    delay_q = '{1};
    stall_q = '{0};
    exp_q.push_back('{32'h0000_8067, 32'h0000_0030});
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    wait_for(0, 5, 50, "accept_final");
    check("sb_drained", exp_q.size(), 32'd0);
    check_b("final_no_err", fetch_err, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

endmodule
